// File: rtl/alu_operand_loader.sv
// Operand capture front-end: two debounced buttons drive a small FSM that
// latches the slide switches into registered a/b operands with a valid flag.

module alu_operand_loader_debounce #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic pulse_o
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          st_q;
  logic          st_dly_q;
  logic [CW-1:0] cnt_q;

  // Synchronize the raw level, then accept a change only after it is stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      st_q     <= 1'b0;
      st_dly_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      st_dly_q <= st_q;
      if (sync2_q == st_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        st_q  <= sync2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign pulse_o = st_q & ~st_dly_q;

endmodule

module alu_operand_loader #(
  parameter int WIDTH     = 6,
  parameter int DB_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_load,
  input  logic             btn_clear,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             valid,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_LOAD_A = 2'b00,
    S_LOAD_B = 2'b01,
    S_READY  = 2'b10,
    S_UNUSED = 2'b11
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             valid_q;
  logic             load_pulse_s;
  logic             clear_pulse_s;

  alu_operand_loader_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_load (
    .clk     (clk),
    .reset   (reset),
    .raw_i   (btn_load),
    .pulse_o (load_pulse_s)
  );

  alu_operand_loader_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clear (
    .clk     (clk),
    .reset   (reset),
    .raw_i   (btn_clear),
    .pulse_o (clear_pulse_s)
  );

  // Capture FSM; clear outranks load, and the unused code recovers to LOAD_A.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
    end else if (clear_pulse_s) begin
      state_q <= S_LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD_A: begin
          if (load_pulse_s) begin
            a_q     <= sw;
            state_q <= S_LOAD_B;
          end else begin
            state_q <= S_LOAD_A;
          end
        end
        S_LOAD_B: begin
          if (load_pulse_s) begin
            b_q     <= sw;
            valid_q <= 1'b1;
            state_q <= S_READY;
          end else begin
            state_q <= S_LOAD_B;
          end
        end
        S_READY: begin
          if (load_pulse_s) begin
            a_q     <= sw;
            valid_q <= 1'b0;
            state_q <= S_LOAD_B;
          end else begin
            state_q <= S_READY;
          end
        end
        default: begin
          state_q <= S_LOAD_A;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign a     = a_q;
  assign b     = b_q;
  assign valid = valid_q;
  assign state = state_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader with a short debounce window.

module tb_alu_operand_loader;

  localparam int WIDTH = 6;
  localparam int DB    = 4;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] sw;
  logic             btn_load;
  logic             btn_clear;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             valid;
  logic [1:0]       state;

  int checks = 0;
  int errors = 0;

  alu_operand_loader #(.WIDTH(WIDTH), .DB_CYCLES(DB)) dut (
    .clk       (clk),
    .reset     (reset),
    .sw        (sw),
    .btn_load  (btn_load),
    .btn_clear (btn_clear),
    .a         (a),
    .b         (b),
    .valid     (valid),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [5:0] ea, input logic [5:0] eb,
                         input logic ev, input logic [1:0] es);
    chk({tag, ".a"}, {2'b00, a}, {2'b00, ea});
    chk({tag, ".b"}, {2'b00, b}, {2'b00, eb});
    chk({tag, ".valid"}, {7'd0, valid}, {7'd0, ev});
    chk({tag, ".state"}, {6'd0, state}, {6'd0, es});
  endtask

  task automatic press(input int n_high);
    btn_load = 1'b1;
    tick(n_high);
    btn_load = 1'b0;
    tick(12);
  endtask

  initial begin
    reset = 1'b1; sw = 6'h3F; btn_load = 1'b0; btn_clear = 1'b0;
    tick(2);
    reset = 1'b0;
    chk_all("reset", 6'd0, 6'd0, 1'b0, 2'b00);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk_all("reset_hold", 6'd0, 6'd0, 1'b0, 2'b00);
    end

    // Basic pair with exact capture latency
    sw = 6'd45; btn_load = 1'b1;
    tick(6);
    chk_all("lat_edge6", 6'd0, 6'd0, 1'b0, 2'b00);
    tick(1);
    chk_all("lat_edge7", 6'd45, 6'd0, 1'b0, 2'b01);
    tick(3); btn_load = 1'b0; tick(12);
    sw = 6'd20;
    press(10);
    chk_all("pair", 6'd45, 6'd20, 1'b1, 2'b10);
    chk("cmp_gt", {7'd0, (a > b)}, 8'd1);

    // Re-arm from READY
    sw = 6'd7;
    press(10);
    chk_all("rearm", 6'd7, 6'd20, 1'b0, 2'b01);

    // Clear and load together: clear wins
    sw = 6'd55; btn_load = 1'b1; btn_clear = 1'b1;
    tick(10);
    btn_load = 1'b0; btn_clear = 1'b0;
    tick(12);
    chk_all("clear_prio", 6'd0, 6'd0, 1'b0, 2'b00);

    // Held button captures exactly once
    sw = 6'd33; btn_load = 1'b1;
    tick(50);
    chk_all("held_during", 6'd33, 6'd0, 1'b0, 2'b01);
    btn_load = 1'b0; tick(12);
    chk_all("held_after", 6'd33, 6'd0, 1'b0, 2'b01);

    // Bounce rejection in LOAD_B
    sw = 6'd50;
    btn_load = 1'b1; tick(1); btn_load = 1'b0; tick(1);
    btn_load = 1'b1; tick(1); btn_load = 1'b0; tick(1);
    btn_load = 1'b1; tick(1); btn_load = 1'b0; tick(12);
    chk_all("bounce", 6'd33, 6'd0, 1'b0, 2'b01);
    press(3);
    chk_all("pulse3", 6'd33, 6'd0, 1'b0, 2'b01);
    press(4);
    chk_all("pulse4", 6'd33, 6'd50, 1'b1, 2'b10);

    // Reset one cycle before the pending capture edge
    sw = 6'd11; btn_load = 1'b1;
    tick(5);
    reset = 1'b1; btn_load = 1'b0;
    tick(1);
    reset = 1'b0;
    chk_all("rst_abort", 6'd0, 6'd0, 1'b0, 2'b00);
    tick(12);
    chk_all("rst_abort_hold", 6'd0, 6'd0, 1'b0, 2'b00);

    // Button held through reset release is seen as a press
    sw = 6'd13; btn_load = 1'b1; reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(6);
    chk_all("held_rst_e6", 6'd0, 6'd0, 1'b0, 2'b00);
    tick(1);
    chk_all("held_rst_e7", 6'd13, 6'd0, 1'b0, 2'b01);
    btn_load = 1'b0; tick(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
